// File: rtl/softmax_denom_accum_if.sv
// Handshake bundle for softmax_denom_accum.
//   master : producer of exponentials and consumer of (num, den) pairs (testbench / datapath)
//   slave  : the accumulator block itself
// Signals:
//   in_valid/in_ready/in_exp           element input stream
//   out_valid/out_ready                pair output handshake
//   out_num/out_den/out_idx/out_last   replayed element, vector sum, position, last flag
//   sat/zero_sum                       per-vector status, meaningful while draining
interface softmax_denom_accum_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 9,
  parameter int unsigned IW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_num;
  logic [SW-1:0] out_den;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          sat;
  logic          zero_sum;

  modport master (
    output in_valid, in_exp, out_ready,
    input  in_ready, out_valid, out_num, out_den, out_idx, out_last, sat, zero_sum
  );

  modport slave (
    input  in_valid, in_exp, out_ready,
    output in_ready, out_valid, out_num, out_den, out_idx, out_last, sat, zero_sum
  );
endinterface

// File: rtl/softmax_denom_accum.sv
// Approximate-softmax denominator accumulator, feeding the 9-bit-denominator divider.
// Collects N exponentials (one per accepted cycle) into a buffer while summing them with
// saturation, then replays every element as a registered (numerator, denominator) pair.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   softmax_denom_accum_if slave modport (input stream, output pairs, status flags)
module softmax_denom_accum #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 9,
  parameter int unsigned IW = $clog2(N)
) (
  input logic                   clk,
  input logic                   rst_n,
  softmax_denom_accum_if.slave  bus
);

  typedef enum logic [0:0] {StAccum, StDrain} state_e;

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_e        r_state;
  logic [DW-1:0] r_buf [N];
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic [SW-1:0] r_sum;
  logic          r_sat_acc;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_out_num;
  logic [SW-1:0] r_out_den;
  logic          r_out_last;
  logic          r_sat;
  logic          r_zero_sum;

  logic          w_in_hs;
  logic          w_out_hs;
  logic [SW:0]   w_sum_ext;
  logic          w_ovf;
  logic [SW-1:0] w_sum_sat;
  logic [IW-1:0] w_rd_nxt;

  assign w_in_hs   = r_in_ready & bus.in_valid;
  assign w_out_hs  = r_out_valid & bus.out_ready;
  // One extra bit catches the carry; anything with that bit set exceeds 2^SW - 1.
  assign w_sum_ext = {1'b0, r_sum} + (SW + 1)'(bus.in_exp);
  assign w_ovf     = w_sum_ext[SW];
  assign w_sum_sat = w_ovf ? {SW{1'b1}} : w_sum_ext[SW-1:0];
  assign w_rd_nxt  = r_rd_ptr + 1'b1;

  // Element storage needs no reset; only slots written this vector are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && w_in_hs) begin
      r_buf[r_wr_ptr] <= bus.in_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StAccum;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sum       <= '0;
      r_sat_acc   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_num   <= '0;
      r_out_den   <= '0;
      r_out_last  <= 1'b0;
      r_sat       <= 1'b0;
      r_zero_sum  <= 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_in_hs) begin
            r_sum     <= w_sum_sat;
            r_sat_acc <= r_sat_acc | w_ovf;
            if (r_wr_ptr == LastIdx) begin
              r_state     <= StDrain;
              r_wr_ptr    <= '0;
              r_rd_ptr    <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              // Slot 0 was filled on an earlier cycle since N >= 2.
              r_out_num   <= r_buf[0];
              r_out_last  <= 1'b0;
              r_sat       <= r_sat_acc | w_ovf;
              // A zero sum is replaced by 1 so the divider never sees Y == 0.
              if (w_sum_sat == '0) begin
                r_out_den  <= SW'(1);
                r_zero_sum <= 1'b1;
              end else begin
                r_out_den  <= w_sum_sat;
                r_zero_sum <= 1'b0;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        StDrain: begin
          if (w_out_hs) begin
            if (r_out_last) begin
              r_state     <= StAccum;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_rd_ptr    <= '0;
              r_sum       <= '0;
              r_sat_acc   <= 1'b0;
              r_wr_ptr    <= '0;
              r_out_num   <= '0;
              r_out_den   <= '0;
              r_out_last  <= 1'b0;
              r_sat       <= 1'b0;
              r_zero_sum  <= 1'b0;
            end else begin
              r_rd_ptr   <= w_rd_nxt;
              r_out_num  <= r_buf[w_rd_nxt];
              r_out_last <= (w_rd_nxt == LastIdx);
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_num   = r_out_num;
  assign bus.out_den   = r_out_den;
  assign bus.out_idx   = r_rd_ptr;
  assign bus.out_last  = r_out_last;
  assign bus.sat       = r_sat;
  assign bus.zero_sum  = r_zero_sum;

endmodule

// File: tb/tb_softmax_denom_accum.sv
// Scoreboard bench for softmax_denom_accum: stimulus pushes expected pairs computed from
// plain integer sums; an independent monitor pops and compares on every output handshake.
module tb_softmax_denom_accum;

  typedef struct packed {
    logic [7:0] num;
    logic [8:0] den;
    logic [2:0] idx;
    logic       last;
    logic       sat;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  exp_t sb [$];
  logic [7:0] vec [8];

  softmax_denom_accum_if #(.N(8), .DW(8), .SW(9)) bus ();

  softmax_denom_accum #(.N(8), .DW(8), .SW(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Stimulus changes at negedge+1; the monitor samples at negedge+2.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: true integer sum, clamp to 511, zero replaced by 1.
  task automatic push_expected();
    int   sum;
    exp_t e;
    sum = 0;
    for (int i = 0; i < 8; i++) sum += int'(vec[i]);
    for (int i = 0; i < 8; i++) begin
      e.num  = vec[i];
      e.den  = (sum > 511) ? 9'd511 : ((sum == 0) ? 9'd1 : 9'(sum));
      e.idx  = 3'(i);
      e.last = (i == 7);
      e.sat  = (sum > 511);
      e.zero = (sum == 0);
      sb.push_back(e);
    end
  endtask

  task automatic feed(input bit gaps, output int first_waits);
    bit hs;
    int waits;
    first_waits = 0;
    push_expected();
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_exp   = 8'($urandom);
          tick();
        end
      end
      check("accum_no_out", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_exp   = vec[i];
      waits = 0;
      forever begin
        hs = bus.in_ready;
        tick();
        if (hs) break;
        waits++;
        if (waits > 20) begin
          check("in_accept_timeout", 1, 0);
          break;
        end
      end
      if (i == 0) first_waits = waits;
    end
    bus.in_valid = 1'b0;
    check("latency_out_valid", bus.out_valid, 1);
  endtask

  task automatic drain(input int stall_idx, input int stall_len, input bit rnd_ready,
                       input bit junk_in);
    int  stalled;
    bit  r;
    bit  done;
    stalled = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (bus.out_valid && int'(bus.out_idx) == stall_idx && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else begin
        r = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      bus.out_ready = r;
      if (junk_in) begin
        bus.in_valid = 1'b1;
        bus.in_exp   = 8'($urandom);
      end
      done = bus.out_valid && bus.out_last && r;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (!done) check("drain_timeout", 1, 0);
    check("post_drain_valid", bus.out_valid, 0);
    check("post_drain_in_ready", bus.in_ready, 1);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {bus.out_valid, bus.out_num, bus.out_den, bus.out_idx, bus.out_last,
                 bus.sat, bus.zero_sum, bus.in_ready}, 64'd1);
  endtask

  // Monitor / scoreboard
  logic        prev_stall;
  logic [21:0] prev_snap;
  always begin
    logic [21:0] snap;
    exp_t        e;
    @(negedge clk);
    #2;
    snap = {bus.out_num, bus.out_den, bus.out_idx, bus.out_last, bus.sat, bus.zero_sum};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid) check("drain_in_ready_low", bus.in_ready, 0);
      if (prev_stall) check("stall_hold", snap, prev_snap);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_num", bus.out_num, e.num);
          check("out_den", bus.out_den, e.den);
          check("out_idx", bus.out_idx, e.idx);
          check("out_last", bus.out_last, e.last);
          check("sat", bus.sat, e.sat);
          check("zero_sum", bus.zero_sum, e.zero);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_snap  = snap;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fw;
    int mode;
    bit seen;
    n_pass = 0;
    n_total = 0;
    prev_stall = 1'b0;
    prev_snap = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_exp = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_state("reset_state");

    // Basic vector
    vec = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);

    // Saturation, then a small vector right after
    vec = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);
    vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);

    // Zero sum
    vec = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);

    // Input gaps, stall at idx 2, junk inputs during drain
    vec = '{8'd3, 8'd250, 8'd7, 8'd9, 8'd11, 8'd13, 8'd15, 8'd17};
    feed(1'b1, fw);
    drain(2, 3, 1'b0, 1'b1);

    // Reset mid-drain at idx 4
    vec = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
    feed(1'b0, fw);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bus.out_valid && bus.out_idx == 3'd4) seen = 1'b1;
      else tick();
    end
    if (!seen) check("reach_idx4_timeout", 1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check_reset_state("reset_mid_drain");
    vec = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);

    // Back-to-back vectors
    for (int i = 0; i < 8; i++) vec[i] = 8'($urandom_range(0, 60));
    feed(1'b0, fw);
    drain(-1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) vec[i] = 8'($urandom_range(0, 60));
    feed(1'b0, fw);
    check("b2b_first_accept", fw, 0);
    drain(-1, 0, 1'b0, 1'b0);

    // Randomized vectors with gaps and random backpressure
    for (int v = 0; v < 12; v++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) begin
        case (mode)
          0: vec[i] = 8'($urandom_range(0, 20));
          1: vec[i] = 8'($urandom);
          2: vec[i] = 8'($urandom_range(40, 90));
          default: vec[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'd0;
        endcase
      end
      feed($urandom_range(0, 1) != 0, fw);
      drain(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 1'b1,
            $urandom_range(0, 1) != 0);
    end

    tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/softmax_denom_accum.md
Name: softmax_denom_accum

Overview:
- Upstream feeder for the 9-bit-denominator array divider in the approximate-softmax datapath.
- Accepts a vector of N 8-bit approximate exponentials one per cycle, buffers them, and accumulates their saturating 9-bit sum.
- Once the vector is complete, replays each element as a registered (numerator, denominator) pair: numerator drives the divider's X input, denominator drives its Y input.

Parameters:
- N, 8, elements per softmax vector (N >= 2).
- DW, 8, width of exponential and numerator (matches divider X width).
- SW, 9, width of sum and denominator (matches divider Y width).
- IW, $clog2(N), element index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_exp valid.
- in_ready  out  1  block can accept an element.
- in_exp  in  DW  unsigned approximate exponential.
- out_valid  out  1  out_num/out_den valid.
- out_ready  in  1  consumer (divider capture stage) takes the pair.
- out_num  out  DW  buffered element, to divider X.
- out_den  out  SW  vector sum, to divider Y.
- out_idx  out  IW  position of out_num within the vector.
- out_last  out  1  high with the element at out_idx == N-1.
- sat  out  1  sum saturated for the current vector; valid during DRAIN.
- zero_sum  out  1  true sum was 0 for the current vector; valid during DRAIN.

Behaviour:
Single clock, synchronous active-low reset. The reset is decided as follows: one clock; reset is synchronous and active-low, on ports clk and rst_n.

Reset:
- State = ACCUM; sum, wr_ptr and rd_ptr = 0.
- out_valid = 0; out_num, out_den, out_idx, out_last, sat, zero_sum all = 0.
- in_ready = 1 from the first cycle after reset.
- Buffer contents need not be reset.
- Reset asserted mid-vector or mid-drain discards all progress. No partial output follows reset.

State ACCUM:
- in_ready = 1, out_valid = 0.
- On in_valid & in_ready: buf[wr_ptr] <= in_exp, wr_ptr++.
- Sum update: sum <= min(sum + in_exp, 2^SW - 1). Compute with an SW+1-bit add and clamp.
- If the add exceeds 2^SW - 1, set sticky sat_acc.
- Accepting the element at wr_ptr == N-1 transitions to DRAIN on the next cycle.
- On that transition: wr_ptr wraps to 0 and rd_ptr = 0.
- On that transition, the final sum includes the Nth element and is latched into out_den.
- If the final sum is 0, out_den = 1 and zero_sum = 1. This avoids division by zero downstream.
- sat <= sat_acc including the Nth element.

State DRAIN:
- in_ready = 0; in_valid is ignored and in_exp is not stored.
- Outputs are registered:
  - out_valid = 1.
  - out_num = buf[rd_ptr].
  - out_idx = rd_ptr.
  - out_last = (rd_ptr == N-1).
  - out_den constant for the whole drain.
- Latency: out_valid rises the cycle after the Nth input handshake.
- On out_valid & out_ready: rd_ptr++ and the next element is presented the following cycle.
- Throughput is 1 pair/cycle while out_ready is held high.
- With out_ready low, all outputs hold stable (no change while valid & !ready).
- Handshake with out_last = 1 completes the vector:
  - Next cycle: state = ACCUM, out_valid = 0, in_ready = 1.
  - sum, sat_acc and wr_ptr are cleared.
  - sat and zero_sum are cleared.
- No overlap: the next vector's first element is accepted no earlier than the cycle after the last output handshake.

Arithmetic:
- All values unsigned.
- Buffer depth is N x DW (register array).
- No rounding. Saturation is the only nonlinearity.

Test Plan:
1. Basic vector, out_ready = 1:
   - Stimulus: reset, then feed 10,20,30,40,50,60,70,80 back-to-back.
   - Required: out_valid the cycle after the 8th accept.
   - Required: 8 consecutive pairs with out_num 10..80, out_den = 360, out_idx 0..7, out_last only on idx 7, sat = 0.
2. Saturation:
   - Stimulus: eight inputs of 100 (true sum 800).
   - Required: out_den = 511 on every pair, sat = 1.
   - Required: the next vector 1,1,1,1,1,1,1,1 gives out_den = 8, sat = 0.
3. Zero sum:
   - Stimulus: eight inputs of 0.
   - Required: out_den = 1, zero_sum = 1, out_num = 0 for all 8 pairs.
4. Input gaps and backpressure:
   - Stimulus: toggle in_valid 1/0 during fill, then hold out_ready = 0 for 3 cycles at idx 2.
   - Required: only valid cycles are stored.
   - Required: outputs frozen at idx 2 while stalled, resuming at idx 3 after out_ready rises.
   - Required: in_ready = 0 and in_valid ignored throughout DRAIN.
5. Reset mid-drain:
   - Stimulus: assert rst_n = 0 for 1 cycle at idx 4.
   - Required: next cycle out_valid = 0, in_ready = 1, all outputs 0.
   - Required: a fresh vector 5,5,5,5,5,5,5,5 yields out_den = 40.
6. Back-to-back vectors:
   - Stimulus: vector A, then vector B presented immediately after A's last handshake.
   - Required: B's first element is accepted the cycle after A's out_last handshake.
   - Required: B's sum excludes every A element.
